mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Shares the single main-memory request/response channel between the instruction-cache miss path (IC) and the data-cache miss/writeback path (DC) of the 3-stage RISC-V core. It grants one requester at a time, registers its request, drives it to memory, and routes the single response beat back to the owner. DC has priority, with a starvation counter that guarantees IC forward progress. One transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 128, cache-line data width
- STARVE_LIMIT, 4, maximum consecutive DC grants while IC waits (≥1)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ic_req_valid  in  1  IC read request
- ic_req_ready  out  1  IC request accepted this cycle
- ic_req_addr  in  ADDR_WIDTH  IC line address
- ic_resp_valid  out  1  IC response beat
- ic_resp_data  out  DATA_WIDTH  IC read data
- dc_req_valid  in  1  DC request
- dc_req_ready  out  1  DC request accepted this cycle
- dc_req_addr  in  ADDR_WIDTH  DC line address
- dc_req_we  in  1  1 = write, 0 = read
- dc_req_wdata  in  DATA_WIDTH  DC write data
- dc_resp_valid  out  1  DC response beat (read data or write ack)
- dc_resp_data  out  DATA_WIDTH  DC read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  registered address
- mem_req_we  out  1  registered write enable
- mem_req_wdata  out  DATA_WIDTH  registered write data
- mem_resp_valid  in  1  memory response beat (reads and writes)
- mem_resp_data  in  DATA_WIDTH  memory read data
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = IC, 1 = DC; owner of current/last transaction

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any req_valid, select winner; assert winner's req_ready (combinational, IDLE only); latch addr/we/wdata (IC: we=0, wdata=0) and owner; go REQ. Otherwise stay.
- Selection: only one valid → that one. Both valid → DC unless starve_cnt == STARVE_LIMIT, then IC.
- starve_cnt (width clog2(STARVE_LIMIT+1)): on DC grant with ic_req_valid=1 → +1 (saturates at STARVE_LIMIT); on DC grant with ic_req_valid=0 → 0; on IC grant → 0.
- REQ: mem_req_valid=1 with latched payload, stable; on mem_req_ready go WAIT.
- WAIT: on mem_resp_valid, assert owner's resp_valid for that cycle with resp_data = mem_resp_data (combinational pass-through); go IDLE.
- mem_resp_valid outside WAIT ignored and dropped; non-owner resp_valid never asserted.
- Requesters hold valid/payload stable until ready; arbiter does not sample payload after grant.
- Write requests complete only on the memory ack beat; dc_resp_data is don't-care for writes but equals mem_resp_data.
- Reset (any state): state IDLE, starve_cnt 0, owner 0, latched payload 0; in-flight transaction abandoned; a late mem_resp_valid is dropped.

## Timing
- Reset values: all ready/valid outputs 0, mem_req_addr/we/wdata 0, busy 0, owner 0.
- Grant cycle T (ready=1) → mem_req_valid=1 from T+1.
- mem_req_ready at cycle A → WAIT from A+1; mem_resp_valid same cycle as acceptance is not possible (memory contract) and is ignored.
- Response at cycle R → resp_valid at R (0-cycle), IDLE at R+1, next grant earliest R+1.
- Minimum 3 cycles per transaction (grant, request accepted, response).
- busy=1 from T+1 through R inclusive.

## Test plan
- Single IC read, addr 0x0000_1000, mem_req_ready=1 immediately, response 0xDEADBEEF… two cycles later → ic_req_ready 1 cycle, mem_req_addr 0x1000 we=0, ic_resp_valid 1 cycle with data, dc_resp_valid never 1.
- IC and DC valid same cycle, DC write 0x2000 → DC granted first, mem_req_we=1; dc_resp_valid on ack; IC granted in cycle after ack.
- STARVE_LIMIT=4, DC valid continuously, IC held valid → grant order DC,DC,DC,DC,IC,DC…; starve_cnt returns 0 after IC grant.
- mem_req_ready held low 5 cycles in REQ → mem_req_valid=1 and addr/we/wdata unchanged every cycle; no new ready to either requester.
- rst asserted in WAIT, mem_resp_valid pulses two cycles after rst released → no resp_valid to either side, busy=0, next request granted normally.
- Spurious mem_resp_valid in IDLE and in REQ → no resp_valid output, state unaffected.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Arbitrates the single main-memory request/response channel between the
// I-cache miss path (IC) and the D-cache miss/writeback path (DC), one transaction at a time.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_resp_valid,
  output logic [DATA_WIDTH-1:0] ic_resp_data,
  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_we,
  input  logic [DATA_WIDTH-1:0] dc_req_wdata,
  output logic                  dc_resp_valid,
  output logic [DATA_WIDTH-1:0] dc_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy,
  output logic                  owner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  grant_ic, grant_dc;

  // DC wins ties unless IC has already watched STARVE_LIMIT DC grants go by.
  always_comb begin
    grant_dc   = 1'b0;
    grant_ic   = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        grant_dc = dc_req_valid && !(ic_req_valid && starve_cnt == LIMIT);
        grant_ic = ic_req_valid && !grant_dc;
        if (grant_dc || grant_ic) state_next = REQ;
      end
      REQ:     if (mem_req_ready)  state_next = WAIT;
      WAIT:    if (mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (grant_dc) begin
        owner_q <= 1'b1;
        addr_q  <= dc_req_addr;
        we_q    <= dc_req_we;
        wdata_q <= dc_req_wdata;
        if (!ic_req_valid)            starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_ic) begin
        owner_q    <= 1'b0;
        addr_q     <= ic_req_addr;
        we_q       <= 1'b0;
        wdata_q    <= '0;
        starve_cnt <= '0;
      end
    end
  end

  assign ic_req_ready  = grant_ic;
  assign dc_req_ready  = grant_dc;
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;

  // Responses arriving outside WAIT are stray beats and never reach a requester.
  assign ic_resp_valid = (state == WAIT) && mem_resp_valid && !owner_q;
  assign dc_resp_valid = (state == WAIT) && mem_resp_valid && owner_q;
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_req_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_we, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_wdata, dc_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data;
  logic          busy, owner;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .owner(owner)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one optional in-flight transaction plus the
  // number of DC wins IC has sat through.
  bit            m_en = 1'b0;
  bit            m_active, m_sent, m_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_streak;
  bit            ic_win, dc_win, exp_ic_resp, exp_dc_resp;

  always @(negedge clk) begin
    dc_win = !m_active && dc_req_valid && !(ic_req_valid && m_streak >= LIMIT);
    ic_win = !m_active && ic_req_valid && !dc_win;
    exp_ic_resp = m_active && m_sent && mem_resp_valid && !m_owner;
    exp_dc_resp = m_active && m_sent && mem_resp_valid && m_owner;
    if (m_en) begin
      checkOutput("busy", busy, m_active);
      checkOutput("owner", owner, m_owner);
      checkOutput("mem_req_valid", mem_req_valid, m_active && !m_sent);
      checkOutput("mem_req_addr", mem_req_addr, m_addr);
      checkOutput("mem_req_we", mem_req_we, m_we);
      checkOutput("mem_req_wdata", mem_req_wdata, m_wdata);
      checkOutput("ic_req_ready", ic_req_ready, ic_win);
      checkOutput("dc_req_ready", dc_req_ready, dc_win);
      checkOutput("ic_resp_valid", ic_resp_valid, exp_ic_resp);
      checkOutput("dc_resp_valid", dc_resp_valid, exp_dc_resp);
      if (exp_ic_resp) checkOutput("ic_resp_data", ic_resp_data, mem_resp_data);
      if (exp_dc_resp) checkOutput("dc_resp_data", dc_resp_data, mem_resp_data);
    end
    if (rst) begin
      m_en = 1'b1; m_active = 1'b0; m_sent = 1'b0; m_owner = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_streak = 0;
    end else if (m_en) begin
      if (dc_win) begin
        m_active = 1'b1; m_owner = 1'b1;
        m_addr = dc_req_addr; m_we = dc_req_we; m_wdata = dc_req_wdata;
        m_streak = ic_req_valid ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
      end else if (ic_win) begin
        m_active = 1'b1; m_owner = 1'b0;
        m_addr = ic_req_addr; m_we = 1'b0; m_wdata = '0;
        m_streak = 0;
      end else if (m_active && !m_sent) begin
        if (mem_req_ready) m_sent = 1'b1;
      end else if (m_active && m_sent && mem_resp_valid) begin
        m_active = 1'b0; m_sent = 1'b0;
      end
    end
  end

  bit ic_acc, dc_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Well-behaved random requesters and memory; payload only changes once accepted or idle.
  task automatic applyStimulus();
    if (ic_acc || !ic_req_valid) begin
      ic_req_valid = ($urandom_range(0, 2) == 0);
      ic_req_addr  = $urandom;
    end
    if (dc_acc || !dc_req_valid) begin
      dc_req_valid = ($urandom_range(0, 1) == 0);
      dc_req_addr  = $urandom;
      dc_req_we    = $urandom_range(0, 1);
      dc_req_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_req_ready  = $urandom_range(0, 1);
    mem_resp_valid = ($urandom_range(0, 2) == 0);
    mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
    rst            = ($urandom_range(0, 99) == 0);
  endtask

  logic [DW-1:0] d1;
  logic [DW-1:0] w2;
  logic [10:0]   order;
  int            ngrants;

  initial begin
    d1 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    w2 = {4{32'hA5A55A5A}};
    rst = 1'b1;
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_we = 0; dc_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("rst_owner", owner, 1'b0);
    checkOutput("rst_mem_req_addr", mem_req_addr, '0);
    tick();
    rst = 1'b0;

    $display("[TB] single IC read");
    ic_req_valid = 1; ic_req_addr = 32'h0000_1000;
    #1 checkOutput("t1_ic_ready", ic_req_ready, 1'b1);
    checkOutput("t1_dc_ready", dc_req_ready, 1'b0);
    tick();
    ic_req_valid = 0; ic_req_addr = '0; mem_req_ready = 1;
    #1 checkOutput("t1_mem_valid", mem_req_valid, 1'b1);
    checkOutput("t1_mem_addr", mem_req_addr, 32'h0000_1000);
    checkOutput("t1_mem_we", mem_req_we, 1'b0);
    checkOutput("t1_ic_ready_once", ic_req_ready, 1'b0);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = d1;
    #1 checkOutput("t1_ic_resp_valid", ic_resp_valid, 1'b1);
    checkOutput("t1_ic_resp_data", ic_resp_data, d1);
    checkOutput("t1_dc_resp_valid", dc_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 0;
    #1 checkOutput("t1_busy_after", busy, 1'b0);

    $display("[TB] simultaneous IC and DC write");
    ic_req_valid = 1; ic_req_addr = 32'h0000_3000;
    dc_req_valid = 1; dc_req_addr = 32'h0000_2000; dc_req_we = 1; dc_req_wdata = w2;
    #1 checkOutput("t2_dc_ready", dc_req_ready, 1'b1);
    checkOutput("t2_ic_ready", ic_req_ready, 1'b0);
    tick();
    dc_req_valid = 0; mem_req_ready = 1;
    #1 checkOutput("t2_mem_we", mem_req_we, 1'b1);
    checkOutput("t2_mem_addr", mem_req_addr, 32'h0000_2000);
    checkOutput("t2_mem_wdata", mem_req_wdata, w2);
    checkOutput("t2_owner", owner, 1'b1);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = '0;
    #1 checkOutput("t2_dc_resp_valid", dc_resp_valid, 1'b1);
    checkOutput("t2_ic_resp_valid", ic_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 0;
    #1 checkOutput("t2_ic_ready_after_ack", ic_req_ready, 1'b1);
    tick();

    $display("[TB] memory stalls in REQ");
    ic_req_valid = 0; dc_req_valid = 1; dc_req_addr = 32'h0000_4000; dc_req_we = 0;
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = (i == 2);
      #1 checkOutput("t4_mem_valid", mem_req_valid, 1'b1);
      checkOutput("t4_mem_addr", mem_req_addr, 32'h0000_3000);
      checkOutput("t4_mem_we", mem_req_we, 1'b0);
      checkOutput("t4_mem_wdata", mem_req_wdata, '0);
      checkOutput("t4_dc_ready", dc_req_ready, 1'b0);
      checkOutput("t4_ic_resp", ic_resp_valid, 1'b0);
      tick();
    end
    mem_resp_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = d1;
    #1 checkOutput("t4_ic_resp_valid", ic_resp_valid, 1'b1);
    tick();
    #1 checkOutput("t6_idle_spurious_ic", ic_resp_valid, 1'b0);
    checkOutput("t6_idle_spurious_dc", dc_resp_valid, 1'b0);
    checkOutput("t6_dc_ready", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 0; mem_resp_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;

    $display("[TB] reset during WAIT");
    #1 checkOutput("t5_busy_wait", busy, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    #1 checkOutput("t5_busy_after_rst", busy, 1'b0);
    tick();
    mem_resp_valid = 1;
    #1 checkOutput("t5_late_ic_resp", ic_resp_valid, 1'b0);
    checkOutput("t5_late_dc_resp", dc_resp_valid, 1'b0);
    checkOutput("t5_late_busy", busy, 1'b0);
    checkOutput("t5_addr_cleared", mem_req_addr, '0);
    tick();
    mem_resp_valid = 0; ic_req_valid = 1; ic_req_addr = 32'h0000_5000;
    #1 checkOutput("t5_regrant", ic_req_ready, 1'b1);
    tick();
    ic_req_valid = 0; mem_req_ready = 1;
    #1 checkOutput("t5_mem_addr", mem_req_addr, 32'h0000_5000);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;

    $display("[TB] starvation guard");
    rst = 1;
    tick();
    rst = 0;
    ic_req_valid = 1; ic_req_addr = 32'h0000_6000;
    dc_req_valid = 1; dc_req_addr = 32'h0000_7000; dc_req_we = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = d1;
    order = '0; ngrants = 0;
    for (int c = 0; c < 60 && ngrants < 11; c++) begin
      #1;
      if (dc_req_ready) begin order = {order[9:0], 1'b1}; ngrants++; end
      else if (ic_req_ready) begin order = {order[9:0], 1'b0}; ngrants++; end
      tick();
    end
    checkOutput("t3_grant_count", ngrants, 11);
    checkOutput("t3_grant_order", order, 11'b11110111101);
    ic_req_valid = 0; dc_req_valid = 0;
    repeat (4) tick();
    mem_req_ready = 0; mem_resp_valid = 0;

    $display("[TB] random traffic");
    ic_acc = 0; dc_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      #1;
      ic_acc = ic_req_ready && !rst;
      dc_acc = dc_req_ready && !rst;
      tick();
    end
    rst = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
